// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: shares one FIFO among NREQ valid/ready producers,
// holding each grant for at most MAX_BURST words and tagging every word with its source ID.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 8,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 4,
    parameter int CNTW      = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      fifo_wr,
    output logic [IDW+DATAWIDTH-1:0]  fifo_din,
    input  logic                      fifo_full,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy,
    output logic [CNTW-1:0]           xfer_count
);

    // Handshake: a word moves from requester i when req_valid[i] && req_ready[i];
    // the same cycle raises fifo_wr. Un-granted requesters see ready low and must hold.

    localparam int NSLOT = 2 ** IDW;
    localparam int BW    = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [IDW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]       grant_nxt, pick_id, next_id;
    logic                 pick_found;
    logic [BW-1:0]        burst_cnt, burst_nxt;
    logic                 xfer;
    logic [NSLOT-1:0]     valid_pad, ready_pad;
    logic [DATAWIDTH-1:0] data_arr [NSLOT];

    // Pad the requester vectors out to the full ID space so any grant_id indexes cleanly.
    assign valid_pad = NSLOT'(req_valid);
    assign req_ready = ready_pad[NREQ-1:0];

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i < NREQ) begin : g_used
            assign data_arr[i] = req_data[i*DATAWIDTH +: DATAWIDTH];
        end else begin : g_pad
            assign data_arr[i] = '0;
        end
    end

    assign next_id = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy    = (state == GRANT);

    // Scan downward so the last hit is the first set bit at or after rr_ptr.
    always_comb begin : rr_search
        int s;
        s          = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = int'(rr_ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            if (valid_pad[IDW'(s)]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(s);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        rr_ptr_nxt = rr_ptr;
        burst_nxt  = burst_cnt;
        ready_pad  = '0;
        xfer       = 1'b0;
        fifo_din   = {grant_id, data_arr[grant_id]};
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_id;
                    burst_nxt = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                ready_pad[grant_id] = !fifo_full;
                xfer                = valid_pad[grant_id] && !fifo_full;
                if (xfer) burst_nxt = burst_cnt + 1'b1;
                // A full FIFO stalls the burst but never ends it.
                if (!valid_pad[grant_id] || (xfer && burst_cnt == BW'(MAX_BURST - 1))) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = next_id;
                end
            end
        endcase
        if (!rstn) begin
            ready_pad = '0;
            xfer      = 1'b0;
        end
        fifo_wr = xfer;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            burst_cnt  <= '0;
            xfer_count <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_id  <= grant_nxt;
            burst_cnt <= burst_nxt;
            if (xfer && xfer_count != {CNTW{1'b1}}) xfer_count <= xfer_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues feed the DUT; a grant/burst model predicts
// ready, write, tag and counters every cycle; directed scenarios pin the model with literals.
module tb_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DW     = 8;
    localparam int IDW    = 2;
    localparam int MAXB   = 4;
    localparam int CNTW   = 16;
    localparam int CNTW_S = 4;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic                 fifo_full = 1'b0;
    logic [NREQ-1:0]      req_ready, req_ready_s;
    logic                 fifo_wr, fifo_wr_s;
    logic [IDW+DW-1:0]    fifo_din, fifo_din_s;
    logic [IDW-1:0]       grant_id, grant_id_s;
    logic                 busy, busy_s;
    logic [CNTW-1:0]      xfer_count;
    logic [CNTW_S-1:0]    xfer_count_s;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .IDW(IDW), .MAX_BURST(MAXB), .CNTW(CNTW)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .grant_id(grant_id), .busy(busy), .xfer_count(xfer_count)
    );

    fifo_wr_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .IDW(IDW), .MAX_BURST(MAXB), .CNTW(CNTW_S)) dut_sat (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready_s), .fifo_wr(fifo_wr_s), .fifo_din(fifo_din_s), .fifo_full(fifo_full),
        .grant_id(grant_id_s), .busy(busy_s), .xfer_count(xfer_count_s)
    );

    // ---------------- scoreboard / model state ----------------
    logic [DW-1:0] exp_q [NREQ][$];
    bit            held [NREQ];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    bit m_busy = 1'b0;
    int m_gid = 0, m_ptr = 0, m_done = 0, m_count = 0;
    int glog[$], blen[$];
    int rst_mark = 0;

    int present_pct = 100, full_pct = 0, rst_pct = 0, full_left = 0;
    bit rst_now = 1'b0, sc6_armed = 1'b0, bp_armed = 1'b0;
    int wr_cnt = 0, first_valid = -1, last_wr = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int cap(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // ---------------- driver + per-cycle compare ----------------
    task automatic step();
        logic [NREQ-1:0]   v, exp_ready;
        logic [IDW+DW-1:0] exp_din;
        bit                exp_wr;
        int                pick;
        @(negedge clk);
        rstn = !(rst_now || ($urandom_range(999) < rst_pct) ||
                 (sc6_armed && m_busy && m_gid == 1 && m_done == 1));
        if (!rstn) sc6_armed = 1'b0;
        fifo_full = (full_left > 0) || ($urandom_range(99) < full_pct);
        if (full_left > 0) full_left--;
        for (int i = 0; i < NREQ; i++) begin
            if (!held[i] && exp_q[i].size() > 0 && $urandom_range(99) < present_pct) held[i] = 1'b1;
            req_valid[i]        = held[i];
            req_data[i*DW +: DW] = held[i] ? exp_q[i][0] : DW'($urandom);
        end
        #1;
        v         = req_valid;
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_din   = '0;
        if (rstn && m_busy) begin
            exp_ready[IDW'(m_gid)] = !fifo_full;
            exp_wr  = v[IDW'(m_gid)] && !fifo_full;
            exp_din = {IDW'(m_gid), (exp_q[m_gid].size() > 0) ? exp_q[m_gid][0] : DW'(0)};
        end
        check("req_ready", req_ready, exp_ready);
        check("fifo_wr", fifo_wr, exp_wr);
        check("fifo_wr_sat", fifo_wr_s, exp_wr);
        check("busy", busy, m_busy);
        check("grant_id", grant_id, m_gid);
        check("xfer_count", xfer_count, cap(m_count, 2**CNTW - 1));
        check("xfer_count_sat", xfer_count_s, cap(m_count, 2**CNTW_S - 1));
        if (exp_wr) check("fifo_din", fifo_din, exp_din);

        if (rstn && first_valid < 0 && v != '0) first_valid = cyc;
        if (exp_wr) begin
            last_wr = cyc;
            wr_cnt++;
            void'(exp_q[m_gid].pop_front());
            held[m_gid] = 1'b0;
        end
        // Next grant/burst situation from the arbitration rules.
        if (!rstn) begin
            m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_done = 0; m_count = 0;
            rst_mark = glog.size();
        end else if (!m_busy) begin
            pick = -1;
            for (int k = 0; k < NREQ && pick < 0; k++)
                if (v[IDW'((m_ptr + k) % NREQ)]) pick = (m_ptr + k) % NREQ;
            if (pick >= 0) begin
                m_busy = 1'b1; m_gid = pick; m_done = 0;
                glog.push_back(pick);
            end
        end else begin
            if (exp_wr) begin
                m_done++;
                m_count++;
            end
            if (!v[IDW'(m_gid)] || m_done == MAXB) begin
                m_busy = 1'b0;
                m_ptr  = (m_gid + 1) % NREQ;
                blen.push_back(m_done);
            end
        end
        if (bp_armed && exp_wr && wr_cnt == 2) begin
            full_left = 5;
            bp_armed  = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_now = 1'b1;
        step();
        step();
        rst_now = 1'b0;
        glog.delete();
        blen.delete();
        wr_cnt = 0; first_valid = -1; last_wr = -1;
    endtask

    function automatic int pending();
        int n = m_busy ? 1 : 0;
        for (int i = 0; i < NREQ; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic run_idle(input int bound);
        int n = 0;
        while (pending() != 0 && n < bound) begin
            step();
            n++;
        end
        check("drain_done", pending(), 0);
        step();
        step();
    endtask

    task automatic load(input int id, input int n);
        for (int j = 0; j < n; j++) exp_q[id].push_back(DW'($urandom));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        do_reset();
        check("reset_xfer_count", xfer_count, 0);
        check("reset_busy", busy, 0);

        // Single requester, 6 words: burst 4, bubble, burst 2.
        load(2, 6);
        run_idle(100);
        check("s1_grants", glog.size(), 2);
        check("s1_grant0", glog[0], 2);
        check("s1_grant1", glog[1], 2);
        check("s1_burst0", blen[0], 4);
        check("s1_burst1", blen[1], 2);
        check("s1_span", last_wr - first_valid + 1, 8);
        check("s1_xfer_count", xfer_count, 6);

        // All requesters continuously valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) load(i, 12);
        run_idle(200);
        check("s2_order0", glog[0], 0);
        check("s2_order1", glog[1], 1);
        check("s2_order2", glog[2], 2);
        check("s2_order3", glog[3], 3);
        check("s2_order4", glog[4], 0);
        for (int b = 0; b < 5; b++) check("s2_burst_len", blen[b], 4);
        check("s2_words", wr_cnt, 48);
        check("s2_xfer_count", xfer_count, 48);
        check("s2_saturated", xfer_count_s, 15);

        // Back-pressure after two words of requester 1.
        do_reset();
        bp_armed = 1'b1;
        load(1, 4);
        run_idle(100);
        check("s3_grants", glog.size(), 1);
        check("s3_burst", blen[0], 4);
        check("s3_span", last_wr - first_valid + 1, 10);

        // Early drop by requester 3 while requester 0 waits.
        do_reset();
        load(2, 1);
        run_idle(50);
        load(3, 1);
        load(0, 4);
        run_idle(100);
        check("s4_grant_a", glog[1], 3);
        check("s4_burst_a", blen[1], 1);
        check("s4_grant_b", glog[2], 0);
        check("s4_burst_b", blen[2], 4);

        // Reset during requester 1's second transfer.
        do_reset();
        for (int i = 0; i < NREQ; i++) load(i, 8);
        sc6_armed = 1'b1;
        run_idle(400);
        check("s5_reset_mark", rst_mark, 2);
        check("s5_first_after_reset", glog[rst_mark], 0);
        check("s5_words", wr_cnt, 32);
        check("s5_xfer_count", xfer_count, 27);

        // Random traffic, stalls and occasional resets.
        do_reset();
        present_pct = 60; full_pct = 25; rst_pct = 3;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (exp_q[i].size() < 8 && $urandom_range(99) < 10) load(i, 1);
            step();
        end
        present_pct = 100; full_pct = 0; rst_pct = 0;
        run_idle(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cycle %0d: got running expected finished", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `fifo` instance among `NREQ` producer engines in the map-inflation pipeline, such as the grid-tile readers and the obstacle-cell generators. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time, holds the grant for a bounded burst and drives the FIFO's `WR`/`dataIn`. Back-pressure comes from the FIFO's `full`. Every written word is tagged with the source requester ID so the consumer can demultiplex.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2 .. 2^`IDW`.
- `DATAWIDTH`, 8: payload width per requester.
- `IDW`, 2: width of the requester ID tag.
- `MAX_BURST`, 4: maximum words transferred per grant; ≥ 1.
- `CNTW`, 16: width of the transfer statistics counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `req_valid` in `NREQ`: bit i high means requester i presents a word.
- `req_data` in `NREQ*DATAWIDTH`: requester i payload at bits [i*DATAWIDTH +: DATAWIDTH].
- `req_ready` out `NREQ`: bit i high means requester i's word is accepted this cycle.
- `fifo_wr` out 1: connects to FIFO `WR`.
- `fifo_din` out `IDW+DATAWIDTH`: connects to FIFO `dataIn`; format {id, payload}.
- `fifo_full` in 1: FIFO `full`.
- `grant_id` out `IDW`: currently/last granted requester.
- `busy` out 1: high in GRANT state.
- `xfer_count` out `CNTW`: total accepted words, saturating.

## Operation
- FSM states: IDLE, GRANT.
- IDLE:
  - If any `req_valid` bit is high, select the first set bit searching from `rr_ptr` upward, wrapping from `NREQ-1` to 0.
  - On selection: load `grant_id`, clear `burst_cnt`, next state GRANT.
  - If no bit is high, stay in IDLE.
- GRANT, with g = `grant_id`:
  - `req_ready[g] = !fifo_full`; all other ready bits are 0.
  - `fifo_wr = req_valid[g] && !fifo_full`.
  - `fifo_din = {g, req_data[g]}`, combinational.
- Transfer: a cycle where `fifo_wr` is 1.
  - Each transfer increments `burst_cnt` and `xfer_count`.
  - `xfer_count` saturates at 2^`CNTW`-1.
- Release from GRANT to IDLE, with `rr_ptr` set to (g+1) mod `NREQ`, on either condition:
  - (a) a transfer occurs with `burst_cnt == MAX_BURST-1`;
  - (b) `req_valid[g]` is 0 in a GRANT cycle.
- Full FIFO during GRANT: no transfer, `burst_cnt` held, grant held indefinitely. Full does not cause release.
- Requesters not granted see `req_ready` = 0 and must hold their data (standard valid/ready).
- `grant_id` retains its last value in IDLE. `fifo_din` is don't-care when `fifo_wr` = 0.
- `burst_cnt` width: clog2(`MAX_BURST`+1).

## Timing
- Reset (rstn low at a clock edge) sets:
  - state IDLE, `rr_ptr` 0, `grant_id` 0, `burst_cnt` 0, `xfer_count` 0;
  - `busy` 0, `fifo_wr` 0, `req_ready` all 0.
- While `rstn` is low, `fifo_wr` and `req_ready` are forced to 0 combinationally.
- Reset mid-burst: the grant is dropped with no partial handshake. The FIFO shares `rstn`, so no word is written in a reset cycle.
- Latency from `req_valid` rising in IDLE to first `req_ready`/`fifo_wr`: 1 cycle. The arbitration cycle is spent in IDLE.
- Peak throughput: `MAX_BURST` words per `MAX_BURST`+1 cycles, because one IDLE bubble occurs per grant.
- Ready/wr depend combinationally on `fifo_full`, which is a registered output of the FIFO, so there is no combinational loop.
- Simultaneous valid on all requesters: grant order is `rr_ptr`, `rr_ptr`+1, … with wrap.
- A requester that drops valid mid-burst releases its grant after that cycle.

## Test plan
- Single requester: req 2 valid with 6 words, `MAX_BURST`=4, FIFO never full.
  - Grants: burst of 4 (fifo_din tag 2), IDLE bubble, then burst of 2.
  - `xfer_count`=6; 8 cycles from first valid to last write.
- All 4 requesters continuously valid after reset.
  - Grant order 0,1,2,3,0; each burst is exactly 4 words; tags match; no word is lost or duplicated.
- Back-pressure: `fifo_full` forced high for 5 cycles mid-burst of req 1 (after 2 words).
  - `req_ready[1]`=0 and `fifo_wr`=0 during the stall; grant is held; `burst_cnt` stays 2.
  - After full drops, 2 more words are written, then release.
- Early drop: req 3 valid for 1 word then low, while req 0 is waiting.
  - Req 3 writes 1 word, then releases; `rr_ptr`=0; the next grant goes to req 0.
- Reset mid-burst: `rstn` low during req 1's second transfer cycle.
  - `fifo_wr`=0 in that cycle; next cycle `busy`=0, `grant_id`=0, `xfer_count`=0.
  - With all valid held, the first grant after reset goes to req 0.
- Saturation: `CNTW`=4 with 20 transfers → `xfer_count` holds 15.
